// File: rtl/lcd_timing_gen_pkg.sv
// Shared types and default panel timing for the LCD timing generator.
package lcd_pkg;

  typedef enum logic {MODE_HV, MODE_DE} lcd_mode_t;
  typedef enum logic [1:0] {R_SYNC, R_BP, R_ACT, R_FP} lcd_region_t;

  localparam int DEF_H_SYNC   = 1;
  localparam int DEF_H_BP     = 159;
  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 160;
  localparam int DEF_V_SYNC   = 1;
  localparam int DEF_V_BP     = 22;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 12;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Panel-side bundle: run/mode controls in, sync/data-enable/coordinates out.
interface lcd_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          en;
  logic          mode;
  logic          hsync;
  logic          vsync;
  logic          data_en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en, mode,
    output hsync, vsync, data_en, x, y, line_start, frame_start
  );

  modport slave (
    output en, mode,
    input  hsync, vsync, data_en, x, y, line_start, frame_start
  );
endinterface

// File: rtl/lcd_timing_gen_axis_timer.sv
// One timing axis: position counter with SYNC/BP/ACTIVE/FP region decode and wrap flag.
module lcd_axis_timer
  import lcd_pkg::*;
#(
  parameter int SYNC   = 1,
  parameter int BP     = 1,
  parameter int ACTIVE = 1,
  parameter int FP     = 1,
  localparam int TOTAL = SYNC + BP + ACTIVE + FP,
  localparam int CW    = idx_width(TOTAL)
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output lcd_region_t   region,
  output logic          wrap
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap = step && (cnt_q == CW'(TOTAL - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (step) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    region = R_FP;
    if (cnt_q < CW'(SYNC))                    region = R_SYNC;
    else if (cnt_q < CW'(SYNC + BP))          region = R_BP;
    else if (cnt_q < CW'(SYNC + BP + ACTIVE)) region = R_ACT;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: registered sync/data-enable/coordinate outputs,
// HV or DE-only mode latched at the frame origin, freeze while en is low.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input logic               clock,
  input logic               reset_L,
  lcd_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = idx_width(H_TOTAL);
  localparam int VW      = idx_width(V_TOTAL);
  localparam int XW      = idx_width(H_ACTIVE);
  localparam int YW      = idx_width(V_ACTIVE);
  localparam logic [HW-1:0] H_OFF = HW'(H_SYNC + H_BP);
  localparam logic [VW-1:0] V_OFF = VW'(V_SYNC + V_BP);
  localparam logic HS_ACT = 1'(HSYNC_POL);
  localparam logic VS_ACT = 1'(VSYNC_POL);

  if (H_SYNC < 1 || H_BP < 1 || H_ACTIVE < 1 || H_FP < 1 ||
      V_SYNC < 1 || V_BP < 1 || V_ACTIVE < 1 || V_FP < 1 ||
      (HSYNC_POL != 0 && HSYNC_POL != 1) ||
      (VSYNC_POL != 0 && VSYNC_POL != 1)) begin : g_param_chk
    $error("lcd_timing_gen: timing parameters must be >= 1 and polarities 0/1");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  lcd_region_t   h_region, v_region;
  logic          h_wrap, v_wrap;

  lcd_axis_timer #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)) u_h_timer (
    .clock(clock), .reset_L(reset_L), .step(bus.en),
    .cnt(h_cnt), .region(h_region), .wrap(h_wrap)
  );

  lcd_axis_timer #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)) u_v_timer (
    .clock(clock), .reset_L(reset_L), .step(bus.en & h_wrap),
    .cnt(v_cnt), .region(v_region), .wrap(v_wrap)
  );

  // Flags marking that the counters currently sit at h=0 / (h=0,v=0); they
  // follow the wrap strobes so no wide compare is needed on the counters.
  logic          at_line_q, at_frame_q;
  lcd_mode_t     mode_q, mode_eff;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          data_en_q, data_en_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, frame_start_q;

  always_comb begin
    mode_eff  = at_frame_q ? lcd_mode_t'(bus.mode) : mode_q;
    hsync_d   = ~HS_ACT;
    vsync_d   = ~VS_ACT;
    data_en_d = (h_region == R_ACT) && (v_region == R_ACT);
    x_d       = '0;
    y_d       = '0;
    if (mode_eff == MODE_HV) begin
      if (h_region == R_SYNC) hsync_d = HS_ACT;
      if (v_region == R_SYNC) vsync_d = VS_ACT;
    end
    if (data_en_d) begin
      x_d = XW'(h_cnt - H_OFF);
      y_d = YW'(v_cnt - V_OFF);
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      at_line_q     <= 1'b1;
      at_frame_q    <= 1'b1;
      mode_q        <= MODE_HV;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      data_en_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (bus.en) begin
      at_line_q     <= h_wrap;
      at_frame_q    <= v_wrap;
      mode_q        <= mode_eff;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      data_en_q     <= data_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= at_line_q;
      frame_start_q <= at_frame_q;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.data_en     = data_en_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 10x6 panel (active 4x3), both sync polarities.
module tb_lcd_timing_gen;

  logic clock   = 1'b0;
  logic reset_L = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   edge_n  = 0;

  lcd_timing_gen_if #(.XW(2), .YW(2)) bus0 ();
  lcd_timing_gen_if #(.XW(2), .YW(2)) bus1 ();

  lcd_timing_gen #(
    .H_SYNC(2), .H_BP(3), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut0 (.clock(clock), .reset_L(reset_L), .bus(bus0));

  lcd_timing_gen #(
    .H_SYNC(2), .H_BP(3), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
    .HSYNC_POL(1), .VSYNC_POL(1)
  ) dut1 (.clock(clock), .reset_L(reset_L), .bus(bus1));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  task automatic chk_px(input string tag, input logic de, input int xv, input int yv);
    chk({tag, ".de"}, 32'(bus0.data_en), 32'(de));
    chk({tag, ".x"},  32'(bus0.x), 32'(xv));
    chk({tag, ".y"},  32'(bus0.y), 32'(yv));
  endtask

  task automatic tick();
    @(posedge clock);
    if (bus0.en) edge_n++;
    @(negedge clock);
  endtask

  task automatic run_to(input int n);
    bus0.en = 1'b1;
    bus1.en = 1'b1;
    while (edge_n < n) tick();
  endtask

  initial begin
    bus0.en = 1'b0; bus0.mode = 1'b0;
    bus1.en = 1'b0; bus1.mode = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst.hs",  32'(bus0.hsync), 1);
    chk("rst.vs",  32'(bus0.vsync), 1);
    chk("rst.fs",  32'(bus0.frame_start), 0);
    chk("rst.ls",  32'(bus0.line_start), 0);
    chk_px("rst", 1'b0, 0, 0);
    chk("rst.hs_pol1", 32'(bus1.hsync), 0);
    chk("rst.vs_pol1", 32'(bus1.vsync), 0);

    reset_L = 1'b1;
    run_to(1);
    chk("e1.fs", 32'(bus0.frame_start), 1);
    chk("e1.ls", 32'(bus0.line_start), 1);
    chk("e1.hs", 32'(bus0.hsync), 0);
    chk("e1.vs", 32'(bus0.vsync), 0);
    chk("e1.hs_pol1", 32'(bus1.hsync), 1);
    chk("e1.vs_pol1", 32'(bus1.vsync), 1);
    run_to(2);
    chk("e2.hs", 32'(bus0.hsync), 0);
    chk("e2.fs", 32'(bus0.frame_start), 0);
    chk("e2.ls", 32'(bus0.line_start), 0);
    run_to(3);
    chk("e3.hs", 32'(bus0.hsync), 1);
    run_to(10);
    chk("e10.vs", 32'(bus0.vsync), 0);
    run_to(11);
    chk("e11.vs", 32'(bus0.vsync), 1);
    chk("e11.ls", 32'(bus0.line_start), 1);
    run_to(25);
    chk_px("e25", 1'b0, 0, 0);
    run_to(26);
    chk_px("e26", 1'b1, 0, 0);
    run_to(29);
    chk_px("e29", 1'b1, 3, 0);
    run_to(30);
    chk_px("e30", 1'b0, 0, 0);

    bus0.mode = 1'b1;
    run_to(41);
    chk("e41.hs_midframe", 32'(bus0.hsync), 0);
    chk("e41.ls", 32'(bus0.line_start), 1);
    run_to(49);
    chk_px("e49", 1'b1, 3, 2);
    run_to(50);
    chk_px("e50", 1'b0, 0, 0);
    run_to(60);
    chk("e60.fs", 32'(bus0.frame_start), 0);
    run_to(61);
    chk("e61.fs", 32'(bus0.frame_start), 1);
    chk("e61.hs_de", 32'(bus0.hsync), 1);
    chk("e61.vs_de", 32'(bus0.vsync), 1);
    run_to(62);
    chk("e62.hs_de", 32'(bus0.hsync), 1);
    run_to(86);
    chk_px("e86", 1'b1, 0, 0);
    run_to(87);
    chk_px("e87", 1'b1, 1, 0);

    bus0.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_px("pause", 1'b1, 1, 0);
    end
    run_to(88);
    chk_px("e88", 1'b1, 2, 0);
    run_to(109);
    chk_px("e109", 1'b1, 3, 2);
    run_to(120);
    chk("e120.fs", 32'(bus0.frame_start), 0);
    run_to(121);
    chk("e121.fs", 32'(bus0.frame_start), 1);
    chk("e121.hs_de", 32'(bus0.hsync), 1);

    bus0.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause.fs_hold", 32'(bus0.frame_start), 1);
    end
    bus0.mode = 1'b0;
    run_to(122);
    chk("e122.fs", 32'(bus0.frame_start), 0);
    chk("e122.hs_mode_held", 32'(bus0.hsync), 1);
    run_to(147);
    chk_px("e147", 1'b1, 1, 0);

    #2 reset_L = 1'b0;
    #1;
    chk_px("async_rst", 1'b0, 0, 0);
    chk("async_rst.hs", 32'(bus0.hsync), 1);
    chk("async_rst.vs", 32'(bus0.vsync), 1);
    @(negedge clock);
    reset_L = 1'b1;
    edge_n  = 0;
    run_to(1);
    chk("restart.fs", 32'(bus0.frame_start), 1);
    chk("restart.ls", 32'(bus0.line_start), 1);
    chk("restart.hs", 32'(bus0.hsync), 0);
    chk_px("restart", 1'b0, 0, 0);
    run_to(3);
    chk("restart3.hs", 32'(bus0.hsync), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
